timer_datapath: RTL and testbench

- Countdown datapath for the egg timer, directly downstream of the Controller FSM.
- Consumes the controller's 3-bit STATE and the switch inputs, and holds the BCD minutes:seconds value.
- Generates the 1 Hz countdown tick and returns a ZERO flag that the controller uses to leave the run state.
- Drives the digit values and the alarm blink toward the seven-segment and LED stage.

---
 rtl/timer_pkg.sv | 17 +
 rtl/bcd_digit_dec.sv | 45 ++++
 rtl/timer_datapath.sv | 123 ++++++++++++
 tb/tb_timer_datapath.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared constants for the egg-timer controller and countdown datapath:
// controller state encoding and BCD digit limits.
package timer_pkg;

    localparam logic [2:0] ST_RESET   = 3'b000;
    localparam logic [2:0] ST_SET_SEC = 3'b001;
    localparam logic [2:0] ST_SET_MIN = 3'b010;
    localparam logic [2:0] ST_READY   = 3'b011;
    localparam logic [2:0] ST_RUN     = 3'b100;
    localparam logic [2:0] ST_PAUSE   = 3'b101;
    localparam logic [2:0] ST_DONE    = 3'b110;

    localparam int BCD_W        = 4;
    localparam int SEC_TENS_MAX = 5;
    localparam int DIGIT_MAX    = 9;

endpackage

// File: rtl/bcd_digit_dec.sv
// One BCD digit with clamped load and borrow-chained decrement.
// Wraps to MAX_VAL on borrow unless hold_i blocks the whole chain.
module bcd_digit_dec
    import timer_pkg::*;
#(
    parameter int MAX_VAL = DIGIT_MAX
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [BCD_W-1:0] load_val_i,
    input  logic             dec_i,
    input  logic             hold_i,
    output logic [BCD_W-1:0] value_o,
    output logic             borrow_o
);

    localparam logic [BCD_W-1:0] MAX_D = BCD_W'(MAX_VAL);

    logic [BCD_W-1:0] value_q, value_d;

    always_comb begin
        value_d = value_q;
        if (clr_i) begin
            value_d = '0;
        end else if (load_i) begin
            value_d = (load_val_i > MAX_D) ? MAX_D : load_val_i;
        end else if (dec_i && !hold_i) begin
            value_d = (value_q == '0) ? MAX_D : value_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value_o  = value_q;
    assign borrow_o = dec_i && (value_q == '0);

endmodule

// File: rtl/timer_datapath.sv
// Egg-timer countdown datapath: BCD mm:ss register, 1 Hz prescaler,
// zero detect and alarm blink, all steered by the controller state.
module timer_datapath
    import timer_pkg::*;
#(
    parameter int TICK_DIV  = 50000000,
    parameter int BLINK_DIV = 25000000
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [2:0] STATE,
    input  logic [7:0] SW,
    output logic [7:0] MIN,
    output logic [7:0] SEC,
    output logic       ZERO,
    output logic       TICK,
    output logic       ALARM
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [2:0] st;
    logic       st_clr, st_set_sec, st_set_min;

    // The illegal encoding 111 behaves exactly like ST_RESET.
    assign st         = (STATE == 3'b111) ? ST_RESET : STATE;
    assign st_clr     = (st == ST_RESET);
    assign st_set_sec = (st == ST_SET_SEC);
    assign st_set_min = (st == ST_SET_MIN);

    logic [PW-1:0] presc_q, presc_d;
    logic          tick_q, tick_d;
    logic          tick_fire;

    always_comb begin
        presc_d   = '0;
        tick_fire = 1'b0;
        case (st)
            ST_RUN: begin
                tick_fire = (presc_q == PRESC_LAST);
                presc_d   = tick_fire ? '0 : presc_q + 1'b1;
            end
            ST_PAUSE: presc_d = presc_q;
            default:  presc_d = '0;
        endcase
        tick_d = tick_fire;
    end

    logic [BW-1:0] blink_q, blink_d;
    logic          alarm_q, alarm_d;

    always_comb begin
        blink_d = '0;
        alarm_d = 1'b0;
        if (st == ST_DONE) begin
            if (blink_q == BLINK_LAST) begin
                blink_d = '0;
                alarm_d = ~alarm_q;
            end else begin
                blink_d = blink_q + 1'b1;
                alarm_d = alarm_q;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
            blink_q <= '0;
            alarm_q <= 1'b0;
        end else begin
            presc_q <= presc_d;
            tick_q  <= tick_d;
            blink_q <= blink_d;
            alarm_q <= alarm_d;
        end
    end

    // borrow[4] means the tick arrived at 00:00; it freezes every digit so nothing wraps.
    logic [4:0] borrow;
    logic [3:0] sec_u, sec_t, min_u, min_t;

    assign borrow[0] = tick_fire;

    bcd_digit_dec #(.MAX_VAL(DIGIT_MAX)) u_sec_u (
        .clk_i(CLK), .rst_ni(RST_N), .clr_i(st_clr),
        .load_i(st_set_sec), .load_val_i(SW[3:0]),
        .dec_i(borrow[0]), .hold_i(borrow[4]),
        .value_o(sec_u), .borrow_o(borrow[1])
    );

    bcd_digit_dec #(.MAX_VAL(SEC_TENS_MAX)) u_sec_t (
        .clk_i(CLK), .rst_ni(RST_N), .clr_i(st_clr),
        .load_i(st_set_sec), .load_val_i(SW[7:4]),
        .dec_i(borrow[1]), .hold_i(borrow[4]),
        .value_o(sec_t), .borrow_o(borrow[2])
    );

    bcd_digit_dec #(.MAX_VAL(DIGIT_MAX)) u_min_u (
        .clk_i(CLK), .rst_ni(RST_N), .clr_i(st_clr),
        .load_i(st_set_min), .load_val_i(SW[3:0]),
        .dec_i(borrow[2]), .hold_i(borrow[4]),
        .value_o(min_u), .borrow_o(borrow[3])
    );

    bcd_digit_dec #(.MAX_VAL(DIGIT_MAX)) u_min_t (
        .clk_i(CLK), .rst_ni(RST_N), .clr_i(st_clr),
        .load_i(st_set_min), .load_val_i(SW[7:4]),
        .dec_i(borrow[3]), .hold_i(borrow[4]),
        .value_o(min_t), .borrow_o(borrow[4])
    );

    assign MIN   = {min_t, min_u};
    assign SEC   = {sec_t, sec_u};
    assign ZERO  = (MIN == 8'h00) && (SEC == 8'h00);
    assign TICK  = tick_q;
    assign ALARM = alarm_q;

endmodule

// File: tb/tb_timer_datapath.sv
// Bench for timer_datapath: directed scenarios plus randomized state/switch
// traffic, every cycle compared against a seconds-based reference model.
module tb_timer_datapath;
    import timer_pkg::*;

    localparam int TICK_DIV  = 4;
    localparam int BLINK_DIV = 2;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic [2:0] STATE;
    logic [7:0] SW;
    logic [7:0] MIN, SEC;
    logic       ZERO, TICK, ALARM;

    int checks   = 0;
    int failures = 0;

    // Reference model state: decimal minutes/seconds plus phase counters.
    int   m_min, m_sec, m_phase, m_blink;
    logic m_tick, m_alarm;

    timer_datapath #(.TICK_DIV(TICK_DIV), .BLINK_DIV(BLINK_DIV)) dut (
        .CLK(CLK), .RST_N(RST_N), .STATE(STATE), .SW(SW),
        .MIN(MIN), .SEC(SEC), .ZERO(ZERO), .TICK(TICK), .ALARM(ALARM)
    );

    always #5 CLK = ~CLK;

    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] t, u;
        t = 4'(v / 10);
        u = 4'(v % 10);
        return {t, u};
    endfunction

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_reset();
        m_min = 0; m_sec = 0; m_phase = 0; m_blink = 0;
        m_tick = 1'b0; m_alarm = 1'b0;
    endtask

    task automatic model_step(input logic [2:0] s, input logic [7:0] sw);
        int total;
        int tens, units;
        tens  = int'(sw[7:4]);
        units = int'(sw[3:0]);
        m_tick = 1'b0;
        if (s == 3'b111 || s == ST_RESET) begin
            model_reset();
            return;
        end
        if (s == ST_SET_SEC) m_sec = min_i(tens, 5) * 10 + min_i(units, 9);
        if (s == ST_SET_MIN) m_min = min_i(tens, 9) * 10 + min_i(units, 9);
        if (s == ST_RUN) begin
            m_phase++;
            if (m_phase == TICK_DIV) begin
                m_phase = 0;
                m_tick  = 1'b1;
                total   = m_min * 60 + m_sec;
                if (total > 0) total--;
                m_min = total / 60;
                m_sec = total % 60;
            end
        end else if (s != ST_PAUSE) begin
            m_phase = 0;
        end
        if (s == ST_DONE) begin
            m_blink++;
            if (m_blink == BLINK_DIV) begin
                m_blink = 0;
                m_alarm = ~m_alarm;
            end
        end else begin
            m_blink = 0;
            m_alarm = 1'b0;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_min"},   {24'b0, MIN},   {24'b0, to_bcd(m_min)});
        check({tag, "_sec"},   {24'b0, SEC},   {24'b0, to_bcd(m_sec)});
        check({tag, "_zero"},  {31'b0, ZERO},  {31'b0, (m_min == 0 && m_sec == 0)});
        check({tag, "_tick"},  {31'b0, TICK},  {31'b0, m_tick});
        check({tag, "_alarm"}, {31'b0, ALARM}, {31'b0, m_alarm});
    endtask

    task automatic cycle(input logic [2:0] s, input logic [7:0] sw, input string tag);
        @(negedge CLK);
        STATE = s;
        SW    = sw;
        @(posedge CLK);
        model_step(s, sw);
        #1;
        check_all(tag);
    endtask

    task automatic load(input logic [7:0] mm, input logic [7:0] ss);
        cycle(ST_SET_MIN, mm, "load_min");
        cycle(ST_SET_SEC, ss, "load_sec");
        cycle(ST_READY, 8'h00, "ready");
    endtask

    task automatic run_until_tick(input int limit, output int n);
        n = 0;
        do begin
            cycle(ST_RUN, 8'h00, "run");
            n++;
        end while (!TICK && n < limit);
        check("tick_within_budget", {31'b0, TICK}, 32'd1);
    endtask

    initial begin
        int n;
        logic [7:0] alarm_exp;
        logic [2:0] rs;

        RST_N = 1'b0;
        STATE = ST_RESET;
        SW    = 8'h00;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        check_all("reset");
        @(negedge CLK);
        RST_N = 1'b1;

        // Clamping on entry
        cycle(ST_SET_SEC, 8'h7A, "set_sec");
        check("clamp_sec_7a", {24'b0, SEC}, 32'h59);
        cycle(ST_SET_SEC, 8'h3C, "set_sec");
        check("clamp_sec_3c", {24'b0, SEC}, 32'h39);
        cycle(ST_SET_MIN, 8'hAB, "set_min");
        check("clamp_min_ab", {24'b0, MIN}, 32'h99);
        check("zero_low_after_set", {31'b0, ZERO}, 32'd0);

        // Full borrow chain from 01:00
        load(8'h01, 8'h00);
        run_until_tick(10, n);
        check("first_tick_latency", n, TICK_DIV);
        check("first_tick_value", {16'b0, MIN, SEC}, 32'h0059);
        for (int i = 0; i < 59; i++) run_until_tick(10, n);
        check("countdown_end", {16'b0, MIN, SEC}, 32'h0000);
        check("countdown_zero", {31'b0, ZERO}, 32'd1);
        run_until_tick(10, n);
        check("hold_at_zero", {16'b0, MIN, SEC}, 32'h0000);

        // Minute and seconds-tens borrows
        load(8'h10, 8'h00);
        run_until_tick(10, n);
        check("minute_borrow", {16'b0, MIN, SEC}, 32'h0959);
        load(8'h00, 8'h10);
        run_until_tick(10, n);
        check("tens_borrow", {16'b0, MIN, SEC}, 32'h0009);

        // Pause keeps the partial second
        load(8'h00, 8'h05);
        for (int i = 0; i < 6; i++) cycle(ST_RUN, 8'h00, "run_pre_pause");
        check("pre_pause_value", {16'b0, MIN, SEC}, 32'h0004);
        for (int i = 0; i < 20; i++) cycle(ST_PAUSE, 8'hFF, "pause");
        check("pause_value", {16'b0, MIN, SEC}, 32'h0004);
        run_until_tick(10, n);
        check("resume_latency", n, 2);
        check("resume_value", {16'b0, MIN, SEC}, 32'h0003);

        // Alarm blink, sampled after each DONE edge
        alarm_exp = 8'b0110_0110;
        for (int i = 0; i < 8; i++) begin
            cycle(ST_DONE, 8'h00, "done");
            check("alarm_pattern", {31'b0, ALARM}, {31'b0, alarm_exp[i]});
        end
        cycle(ST_READY, 8'h00, "after_done");
        check("alarm_cleared", {31'b0, ALARM}, 32'd0);

        // Asynchronous reset between edges while running at 00:30
        load(8'h00, 8'h30);
        cycle(ST_RUN, 8'h00, "run_pre_rst");
        cycle(ST_RUN, 8'h00, "run_pre_rst");
        #2;
        RST_N = 1'b0;
        #1;
        model_reset();
        check("async_min", {24'b0, MIN}, 32'h00);
        check("async_sec", {24'b0, SEC}, 32'h00);
        check("async_zero", {31'b0, ZERO}, 32'd1);
        check("async_tick", {31'b0, TICK}, 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        STATE = 3'b111;
        SW    = 8'h25;
        @(posedge CLK);
        model_step(3'b111, 8'h25);
        #1;
        check_all("illegal_after_reset");
        cycle(ST_SET_SEC, 8'h25, "set_sec");
        check("set_before_illegal", {24'b0, SEC}, 32'h25);
        cycle(3'b111, 8'h25, "illegal");
        check("illegal_clears", {24'b0, SEC}, 32'h00);

        // Randomized traffic, biased toward running
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 11) >= 8) rs = ST_RUN;
            else rs = 3'($urandom_range(0, 7));
            cycle(rs, 8'($urandom_range(0, 255)), "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
